// File: rtl/uart_pkg.sv
// uart_pkg: shared types and elaboration helpers for the uart_param block.
//   rx_state_t / tx_state_t : receiver and transmitter FSM encodings
//   uart_div()              : sysclk cycles per oversampling tick
//   DATA_BITS_* / STOP_BITS_*: legal parameter ranges
// The optional parity bit is controlled by the UART_PARITY_EN macro in uart_param.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 8;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // Integer-truncated divider from sysclk to the RX oversampling tick.
    function automatic int uart_div(input int clk_hz, input int baud, input int oversample);
        return clk_hz / (baud * oversample);
    endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running divider emitting a one-cycle tick every DIV cycles.
//   sysclk : clock
//   rst    : asynchronous active-low reset
//   tick   : one-cycle strobe, period DIV sysclk cycles
module uart_tick_gen #(
    parameter int DIV = 10
) (
    input  logic sysclk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CNT_LAST) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + 1'b1;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_param.sv
// uart_param: parametrised full-duplex UART on a single clock.
// Optional feature: define UART_PARITY_EN to append/check a parity bit.
// Ports:
//   sysclk        : clock, all logic on posedge
//   rst           : asynchronous active-low reset
//   uart_rxd      : serial input (asynchronous, synchronised internally)
//   uart_txd      : serial output, idle high
//   tx_data       : word to send
//   tx_valid      : tx_data valid
//   tx_ready      : transmitter can accept a word
//   rx_data       : last received word, held until the next one
//   rx_valid      : one-cycle strobe for a new rx_data
//   rx_frame_err  : qualifies rx_valid, a stop bit was sampled low
//   rx_parity_err : qualifies rx_valid, parity mismatch (0 without parity)
module uart_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 sysclk,
    input  logic                 rst,
    input  logic                 uart_rxd,
    output logic                 uart_txd,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err
);

    localparam int DIV = uart_div(CLK_HZ, BAUD, OVERSAMPLE);
    localparam int BIT = DIV * OVERSAMPLE;
    localparam int TCW = $clog2(BIT);
    localparam int OCW = $clog2(OVERSAMPLE);

    localparam logic [TCW-1:0] BIT_LAST  = TCW'(BIT - 1);
    localparam logic [OCW-1:0] OS_LAST   = OCW'(OVERSAMPLE - 1);
    localparam logic [OCW-1:0] HALF_LAST = OCW'(OVERSAMPLE / 2 - 1);
    localparam logic [2:0]     DB_LAST   = 3'(DATA_BITS - 1);
    localparam logic [2:0]     SB_LAST   = 3'(STOP_BITS - 1);

    if (DIV < 2) begin : g_div_chk
        $error("uart_param: CLK_HZ/(BAUD*OVERSAMPLE) must be at least 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_os_chk
        $error("uart_param: OVERSAMPLE must be even and at least 8");
    end
    if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX) begin : g_db_chk
        $error("uart_param: DATA_BITS out of range");
    end
    if (STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX) begin : g_sb_chk
        $error("uart_param: STOP_BITS out of range");
    end
    if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_par_chk
        $error("uart_param: PARITY_ODD must be 0 or 1");
    end

`ifdef UART_PARITY_EN
    function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
        return (^d) ^ (PARITY_ODD != 0);
    endfunction
`endif

    logic tick;

    uart_tick_gen #(
        .DIV (DIV)
    ) u_tick_gen (
        .sysclk (sysclk),
        .rst    (rst),
        .tick   (tick)
    );

    // ---------------- RX input synchroniser + edge history ----------------
    logic [1:0] rxd_sync;
    logic       rxd_s;
    logic       rxd_prev;

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            rxd_sync <= 2'b11;
            rxd_prev <= 1'b1;
        end else begin
            rxd_sync <= {rxd_sync[0], uart_rxd};
            rxd_prev <= rxd_sync[1];
        end
    end

    assign rxd_s = rxd_sync[1];

    // ---------------- RX FSM ----------------
    rx_state_t            rx_state_q, rx_state_d;
    logic [OCW-1:0]       rx_tcnt_q, rx_tcnt_d;
    logic [2:0]           rx_bcnt_q, rx_bcnt_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_stop_low_q, rx_stop_low_d;
    logic [DATA_BITS-1:0] rx_data_d;
    logic                 rx_valid_d;
    logic                 rx_ferr_d;
    logic                 rx_bit_end;
`ifdef UART_PARITY_EN
    logic                 rx_par_q, rx_par_d;
    logic                 rx_perr_d;
`endif

    // Sample point inside a DATA/PARITY/STOP bit: the OVERSAMPLE-th tick.
    assign rx_bit_end = tick && (rx_tcnt_q == OS_LAST);

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_tcnt_d     = rx_tcnt_q;
        rx_bcnt_d     = rx_bcnt_q;
        rx_shift_d    = rx_shift_q;
        rx_stop_low_d = rx_stop_low_q;
        rx_data_d     = rx_data;
        rx_valid_d    = 1'b0;
        rx_ferr_d     = rx_frame_err;
`ifdef UART_PARITY_EN
        rx_par_d      = rx_par_q;
        rx_perr_d     = rx_parity_err;
`endif
        if ((rx_state_q inside {RX_DATA, RX_PARITY, RX_STOP}) && tick) begin
            rx_tcnt_d = rx_bit_end ? '0 : rx_tcnt_q + 1'b1;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rxd_prev && !rxd_s) begin
                    rx_state_d = RX_START;
                    rx_tcnt_d  = '0;
                end
            end
            RX_START: begin
                // Half a bit in, the line must still be low or it was a glitch.
                if (tick) begin
                    if (rx_tcnt_q == HALF_LAST) begin
                        rx_tcnt_d     = '0;
                        rx_bcnt_d     = '0;
                        rx_stop_low_d = 1'b0;
                        rx_state_d    = rxd_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_tcnt_d = rx_tcnt_q + 1'b1;
                    end
                end
            end
            RX_DATA: begin
                if (rx_bit_end) begin
                    rx_shift_d = {rxd_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bcnt_q == DB_LAST) begin
                        rx_bcnt_d = '0;
`ifdef UART_PARITY_EN
                        rx_state_d = RX_PARITY;
`else
                        rx_state_d = RX_STOP;
`endif
                    end else begin
                        rx_bcnt_d = rx_bcnt_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_bit_end) begin
`ifdef UART_PARITY_EN
                    rx_par_d   = rxd_s;
`endif
                    rx_bcnt_d  = '0;
                    rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_bit_end) begin
                    if (rx_bcnt_q == SB_LAST) begin
                        rx_data_d  = rx_shift_q;
                        rx_valid_d = 1'b1;
                        rx_ferr_d  = rx_stop_low_q | ~rxd_s;
`ifdef UART_PARITY_EN
                        rx_perr_d  = rx_par_q ^ parity_of(rx_shift_q);
`endif
                        // A low stop bit may be a break: wait for the line to idle.
                        rx_state_d = (rx_stop_low_q | ~rxd_s) ? RX_BREAK : RX_IDLE;
                    end else begin
                        rx_bcnt_d     = rx_bcnt_q + 1'b1;
                        rx_stop_low_d = rx_stop_low_q | ~rxd_s;
                    end
                end
            end
            RX_BREAK: begin
                if (rxd_s) begin
                    rx_state_d = RX_IDLE;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            rx_state_q    <= RX_IDLE;
            rx_tcnt_q     <= '0;
            rx_bcnt_q     <= '0;
            rx_shift_q    <= '0;
            rx_stop_low_q <= 1'b0;
            rx_data       <= '0;
            rx_valid      <= 1'b0;
            rx_frame_err  <= 1'b0;
`ifdef UART_PARITY_EN
            rx_par_q      <= 1'b0;
            rx_parity_err <= 1'b0;
`endif
        end else begin
            rx_state_q    <= rx_state_d;
            rx_tcnt_q     <= rx_tcnt_d;
            rx_bcnt_q     <= rx_bcnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_stop_low_q <= rx_stop_low_d;
            rx_data       <= rx_data_d;
            rx_valid      <= rx_valid_d;
            rx_frame_err  <= rx_ferr_d;
`ifdef UART_PARITY_EN
            rx_par_q      <= rx_par_d;
            rx_parity_err <= rx_perr_d;
`endif
        end
    end

`ifndef UART_PARITY_EN
    assign rx_parity_err = 1'b0;
`endif

    // ---------------- TX FSM ----------------
    tx_state_t            tx_state_q, tx_state_d;
    logic [TCW-1:0]       tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bcnt_q, tx_bcnt_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 txd_q, txd_d;
    logic                 tx_bit_end;
`ifdef UART_PARITY_EN
    logic                 tx_par_q, tx_par_d;
`endif

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bcnt_d  = tx_bcnt_q;
        tx_shift_d = tx_shift_q;
        txd_d      = txd_q;
`ifdef UART_PARITY_EN
        tx_par_d   = tx_par_q;
`endif
        tx_bit_end = (tx_cnt_q == BIT_LAST);
        // Ready is also raised in the final cycle of the last stop bit so a
        // waiting word starts its start bit with no idle gap.
        tx_ready   = (tx_state_q == TX_IDLE) ||
                     ((tx_state_q == TX_STOP) && (tx_bcnt_q == SB_LAST) && tx_bit_end);

        if (tx_state_q != TX_IDLE) begin
            tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
        end

        if (tx_valid && tx_ready) begin
            tx_state_d = TX_START;
            tx_cnt_d   = '0;
            tx_shift_d = tx_data;
`ifdef UART_PARITY_EN
            tx_par_d   = parity_of(tx_data);
`endif
            txd_d      = 1'b0;
        end else if (tx_bit_end) begin
            case (tx_state_q)
                TX_START: begin
                    tx_state_d = TX_DATA;
                    tx_bcnt_d  = '0;
                    txd_d      = tx_shift_q[0];
                end
                TX_DATA: begin
                    if (tx_bcnt_q == DB_LAST) begin
                        tx_bcnt_d = '0;
`ifdef UART_PARITY_EN
                        tx_state_d = TX_PARITY;
                        txd_d      = tx_par_q;
`else
                        tx_state_d = TX_STOP;
                        txd_d      = 1'b1;
`endif
                    end else begin
                        tx_bcnt_d  = tx_bcnt_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        txd_d      = tx_shift_q[1];
                    end
                end
                TX_PARITY: begin
                    tx_state_d = TX_STOP;
                    tx_bcnt_d  = '0;
                    txd_d      = 1'b1;
                end
                TX_STOP: begin
                    txd_d = 1'b1;
                    if (tx_bcnt_q == SB_LAST) begin
                        tx_state_d = TX_IDLE;
                    end else begin
                        tx_bcnt_d = tx_bcnt_q + 1'b1;
                    end
                end
                default: begin
                    tx_state_d = TX_IDLE;
                    txd_d      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or negedge rst) begin
        if (!rst) begin
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bcnt_q  <= '0;
            tx_shift_q <= '0;
            txd_q      <= 1'b1;
`ifdef UART_PARITY_EN
            tx_par_q   <= 1'b0;
`endif
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bcnt_q  <= tx_bcnt_d;
            tx_shift_q <= tx_shift_d;
            txd_q      <= txd_d;
`ifdef UART_PARITY_EN
            tx_par_q   <= tx_par_d;
`endif
        end
    end

    assign uart_txd = txd_q;

endmodule
